// File: rtl/hd_8b10b_pkg.sv
// Shared definitions for the hd_8b10b link: K-code bytes, scheduler states
// and the symbol type presented to the 8b10b encoder.
package hd_8b10b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_2 = 8'h5C;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    IDLE  = 2'd1,
    DATA  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } symbol_t;

endpackage

// File: rtl/hd_8b10b_rr_arb.sv
// Two-way round-robin picker: the preferred requester wins a tie, otherwise
// whichever requester is active wins.
module hd_8b10b_rr_arb (
  input  logic [1:0] req,
  input  logic       prefer,
  output logic       gnt_valid,
  output logic       gnt
);

  assign gnt_valid = |req;
  assign gnt       = req[prefer] ? prefer : ~prefer;

endmodule

// File: rtl/hd_8b10b_tx_sched.sv
// Transmit scheduler for the shared 8b10b encoder: alignment comma train,
// round-robin marked bursts from two byte channels, idles and forced commas.
module hd_8b10b_tx_sched
  import hd_8b10b_pkg::*;
#(
  parameter int ALIGN_LEN    = 16,
  parameter int COMMA_PERIOD = 64,
  parameter int MAX_BURST    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  output logic       ch1_ready,
  input  logic       enc_ready,
  output logic       enc_valid,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       grant,
  output logic       align_done
);

  localparam int AW = $clog2(ALIGN_LEN + 1);
  localparam int CW = $clog2(COMMA_PERIOD);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_LEN - 1);
  localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_PERIOD - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  sched_state_t  state, nxt_state;
  symbol_t       sym, nxt_sym;
  logic [AW-1:0] align_cnt;
  logic [CW-1:0] comma_cnt;
  logic [BW-1:0] burst_cnt;
  logic          load, cur_valid, gnt_valid, gnt;
  logic          nxt_grant, sel0, sel1, burst_clr, burst_inc, set_align, is_comma;

  assign load      = ~enc_valid | enc_ready;
  assign cur_valid = grant ? ch1_valid : ch0_valid;
  assign ch0_ready = load & sel0;
  assign ch1_ready = load & sel1;
  assign enc_data  = sym.data;
  assign enc_k     = sym.k;
  assign is_comma  = nxt_sym.k && (nxt_sym.data == K28_5);

  // Re-arbitration always favours the channel that did not own the last burst.
  hd_8b10b_rr_arb u_arb (
    .req       ({ch1_valid, ch0_valid}),
    .prefer    (~grant),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_comb begin
    nxt_sym   = '{k: 1'b1, data: K28_5};
    nxt_state = state;
    nxt_grant = grant;
    sel0      = 1'b0;
    sel1      = 1'b0;
    burst_clr = 1'b0;
    burst_inc = 1'b0;
    set_align = 1'b0;
    if (state == ALIGN) begin
      if (align_cnt == ALIGN_LAST) begin
        nxt_state = IDLE;
        set_align = 1'b1;
      end
    end else if (comma_cnt != COMMA_LAST) begin
      if (state == DATA && cur_valid && burst_cnt < BURST_MAX) begin
        nxt_sym   = '{k: 1'b0, data: (grant ? ch1_data : ch0_data)};
        sel0      = ~grant;
        sel1      = grant;
        burst_inc = 1'b1;
      end else if (gnt_valid) begin
        nxt_sym   = '{k: 1'b1, data: (gnt ? K28_2 : K28_0)};
        nxt_grant = gnt;
        burst_clr = 1'b1;
        nxt_state = DATA;
      end else begin
        nxt_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_valid  <= 1'b0;
      sym        <= '{k: 1'b1, data: K28_5};
      grant      <= 1'b1;
      align_done <= 1'b0;
      state      <= ALIGN;
      align_cnt  <= '0;
      comma_cnt  <= '0;
      burst_cnt  <= '0;
    end else if (load) begin
      enc_valid <= 1'b1;
      sym       <= nxt_sym;
      state     <= nxt_state;
      grant     <= nxt_grant;
      if (set_align)
        align_done <= 1'b1;
      if (state == ALIGN)
        align_cnt <= align_cnt + 1'b1;
      comma_cnt <= is_comma ? '0 : comma_cnt + 1'b1;
      if (burst_clr)
        burst_cnt <= '0;
      else if (burst_inc)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_8b10b_tx_sched.sv
// Scoreboard bench for hd_8b10b_tx_sched: a transaction-level model predicts
// the symbol stream from the byte queues offered by each channel.
module tb_hd_8b10b_tx_sched;

  localparam int ALIGN_LEN    = 16;
  localparam int COMMA_PERIOD = 64;
  localparam int MAX_BURST    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [7:0] ch0_data = 8'h00, ch1_data = 8'h00;
  logic       ch0_ready, ch1_ready;
  logic       enc_ready = 1'b0;
  logic       enc_valid, enc_k, grant, align_done;
  logic [7:0] enc_data;

  int passed = 0;
  int total  = 0;
  logic [7:0] dq0[$];
  logic [7:0] dq1[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  hd_8b10b_tx_sched #(
    .ALIGN_LEN    (ALIGN_LEN),
    .COMMA_PERIOD (COMMA_PERIOD),
    .MAX_BURST    (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch0_valid  (ch0_valid),
    .ch0_data   (ch0_data),
    .ch0_ready  (ch0_ready),
    .ch1_valid  (ch1_valid),
    .ch1_data   (ch1_data),
    .ch1_ready  (ch1_ready),
    .enc_ready  (enc_ready),
    .enc_valid  (enc_valid),
    .enc_data   (enc_data),
    .enc_k      (enc_k),
    .grant      (grant),
    .align_done (align_done)
  );

  task automatic drive_heads();
    ch0_valid = (dq0.size() != 0);
    ch0_data  = (dq0.size() != 0) ? dq0[0] : 8'h00;
    ch1_valid = (dq1.size() != 0);
    ch1_data  = (dq1.size() != 0) ? dq1[0] : 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enc_ready = 1'b0;
    dq0.delete();
    dq1.delete();
    exp_q.delete();
    drive_heads();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Predicts the symbol stream from reset, given that each channel stays
  // valid exactly while it still has bytes queued.
  task automatic build_model(input int nsym);
    int st = 0, ac = 0, cc = 0, bc = 0, i0 = 0, i1 = 0, p;
    logic g = 1'b1;
    logic v0, v1;
    logic [8:0] s;
    for (int n = 0; n < nsym; n++) begin
      v0 = (i0 < dq0.size());
      v1 = (i1 < dq1.size());
      s = 9'h1BC;
      if (st == 0) begin
        ac++;
        if (ac == ALIGN_LEN) st = 1;
      end else if (cc == COMMA_PERIOD - 1) begin
        s = 9'h1BC;
      end else if (st == 2 && (g ? v1 : v0) && bc < MAX_BURST) begin
        if (g) begin s = {1'b0, dq1[i1]}; i1++; end
        else   begin s = {1'b0, dq0[i0]}; i0++; end
        bc++;
      end else begin
        if (v0 && v1) p = g ? 0 : 1;
        else if (v0)  p = 0;
        else if (v1)  p = 1;
        else          p = -1;
        if (p < 0) st = 1;
        else begin
          s  = (p == 1) ? 9'h15C : 9'h11C;
          g  = (p == 1);
          bc = 0;
          st = 2;
        end
      end
      cc = (s == 9'h1BC) ? 0 : cc + 1;
      exp_q.push_back(s);
    end
  endtask

  task automatic load_streams(input int n0, input int n1, input int nsym);
    for (int i = 0; i < n0; i++) dq0.push_back(8'(i));
    for (int i = 0; i < n1; i++) dq1.push_back(8'(8'h80 + i));
    build_model(nsym);
    drive_heads();
  endtask

  task automatic consume(input string name, input int nsym, input int stall_pct,
                         input bit chk_align, output int rdy0_cnt);
    int got = 0, cyc = 0, run = 0;
    int limit = nsym * 8 + 200;
    logic stalled, take0, take1;
    logic [8:0] held, act, expv;
    rdy0_cnt = 0;
    while (got < nsym && cyc < limit) begin
      @(negedge clk);
      enc_ready = ($urandom_range(99) >= stall_pct);
      #1;
      stalled = enc_valid && !enc_ready;
      held = {enc_k, enc_data};
      if (stalled) begin
        total++;
        if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0)
          $display("FAIL %s stall_ready: ch0_ready=%b ch1_ready=%b required 0/0", name, ch0_ready, ch1_ready);
        else passed++;
      end
      if (dq0.size() == 0) begin
        total++;
        if (ch0_ready !== 1'b0) $display("FAIL %s idle_ch0_ready: got %b required 0", name, ch0_ready);
        else passed++;
      end
      if (dq1.size() == 0) begin
        total++;
        if (ch1_ready !== 1'b0) $display("FAIL %s idle_ch1_ready: got %b required 0", name, ch1_ready);
        else passed++;
      end
      if (enc_valid === 1'b1 && enc_ready) begin
        act = {enc_k, enc_data};
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
        total++;
        if (act !== expv)
          $display("FAIL %s symbol[%0d]: got k=%b data=%h required k=%b data=%h",
                   name, got, act[8], act[7:0], expv[8], expv[7:0]);
        else passed++;
        if (chk_align && got < ALIGN_LEN + 4) begin
          total++;
          if (align_done !== (got >= ALIGN_LEN - 1))
            $display("FAIL %s align_done[%0d]: got %b required %b", name, got, align_done, (got >= ALIGN_LEN - 1));
          else passed++;
        end
        if (act == 9'h1BC) begin
          total++;
          if (run > COMMA_PERIOD - 1)
            $display("FAIL %s comma_gap: got %0d required <= %0d", name, run, COMMA_PERIOD - 1);
          else passed++;
          run = 0;
        end else run++;
        got++;
      end
      take0 = ch0_ready;
      take1 = ch1_ready;
      if (take0) rdy0_cnt++;
      @(posedge clk);
      #1;
      if (stalled) begin
        total++;
        if ({enc_k, enc_data} !== held)
          $display("FAIL %s stall_hold: got %h required %h", name, {enc_k, enc_data}, held);
        else passed++;
      end
      if (take0 && dq0.size() != 0) void'(dq0.pop_front());
      if (take1 && dq1.size() != 0) void'(dq1.pop_front());
      drive_heads();
      cyc++;
    end
    if (got < nsym) begin
      total++;
      $display("FAIL %s timeout: got %0d symbols required %0d", name, got, nsym);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total += 5;
    if (enc_valid !== 1'b0) $display("FAIL reset enc_valid: got %b required 0", enc_valid); else passed++;
    if (enc_data !== 8'hBC) $display("FAIL reset enc_data: got %h required bc", enc_data); else passed++;
    if (enc_k !== 1'b1) $display("FAIL reset enc_k: got %b required 1", enc_k); else passed++;
    if (grant !== 1'b1) $display("FAIL reset grant: got %b required 1", grant); else passed++;
    if (align_done !== 1'b0) $display("FAIL reset align_done: got %b required 0", align_done); else passed++;
  endtask

  task automatic test_align();
    int r0;
    do_reset();
    load_streams(0, 0, ALIGN_LEN + 12);
    consume("align", ALIGN_LEN + 12, 0, 1'b1, r0);
  endtask

  task automatic test_drop_valid();
    int r0;
    do_reset();
    load_streams(5, 0, ALIGN_LEN + 10);
    consume("drop_valid", ALIGN_LEN + 10, 0, 1'b0, r0);
    total++;
    if (r0 !== 5) $display("FAIL drop_valid ready_cycles: got %0d required 5", r0);
    else passed++;
  endtask

  task automatic test_two_channel();
    int r0;
    do_reset();
    load_streams(100, 100, ALIGN_LEN + 150);
    consume("two_channel", ALIGN_LEN + 150, 0, 1'b0, r0);
  endtask

  task automatic test_forced_comma();
    int r0;
    do_reset();
    load_streams(100, 0, ALIGN_LEN + 110);
    consume("forced_comma", ALIGN_LEN + 110, 0, 1'b0, r0);
  endtask

  task automatic test_stall();
    int r0;
    do_reset();
    load_streams(60, 60, ALIGN_LEN + 100);
    consume("stall", ALIGN_LEN + 100, 50, 1'b0, r0);
  endtask

  task automatic test_reset_mid_burst();
    int r0;
    do_reset();
    load_streams(80, 80, ALIGN_LEN + 40);
    consume("mid_pre", ALIGN_LEN + 40, 0, 1'b0, r0);
    #2;
    rst = 1'b1;
    #1;
    total += 2;
    if (enc_valid !== 1'b0) $display("FAIL mid_reset enc_valid: got %b required 0", enc_valid); else passed++;
    if (align_done !== 1'b0) $display("FAIL mid_reset align_done: got %b required 0", align_done); else passed++;
    dq0.delete();
    dq1.delete();
    exp_q.delete();
    drive_heads();
    @(negedge clk);
    rst = 1'b0;
    load_streams(30, 30, ALIGN_LEN + 40);
    consume("mid_post", ALIGN_LEN + 40, 0, 1'b1, r0);
  endtask

  initial begin
    test_reset();
    test_align();
    test_drop_valid();
    test_two_channel();
    test_forced_comma();
    test_stall();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
